slice_ctrl: RTL and testbench

SLICE_CTRL -- requirements
Module: slice_ctrl

---
 rtl/slice_pkg.sv | 27 ++
 rtl/slice_ctrl_key_debounce.sv | 70 +++++++
 rtl/slice_ctrl.sv | 145 ++++++++++++++
 tb/tb_slice_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_pkg.sv
// ============================================================================
//  Module      : slice_pkg
//  Description : Shared types and constants for the slice job controller:
//                FSM state encoding, slice-counter width and default job size.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package slice_pkg;

  // Width of the completed-slice counter (holds 0..16 without wrapping).
  localparam int SLICE_W = 5;

  // Default number of slices that make up one job.
  localparam int DEFAULT_NUM_SLICES = 16;

  // Job controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : slice_pkg

`default_nettype wire

// File: rtl/slice_ctrl_key_debounce.sv
// ============================================================================
//  Module      : key_debounce
//  Description : Push-button conditioner. A 2-FF synchronizer feeds a
//                stability counter; once the synchronized level has differed
//                from the accepted level for DB_CYCLES consecutive cycles the
//                new level is accepted. Acceptance of a press (high-to-low)
//                emits a one-cycle pulse; release emits nothing.
//
//                The pulse is registered and is high during the cycle that
//                ends on clk edge DB_CYCLES+3 after the raw edge, so logic
//                sampling it acts on exactly that edge.
//
//  Ports       : clk      in  system clock
//                rst_n    in  asynchronous active-low reset
//                i_key_n  in  raw active-low key, asynchronous to clk
//                o_press  out one-cycle press pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  // Counter only needs to reach DB_CYCLES-1; keep at least one bit.
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;   // accepted (debounced) key level
  logic [CW-1:0] r_cnt;
  logic          r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // For a single-bit signal, "synchronized level changed" is the same as
      // "synchronized level fell back to the accepted level", so matching the
      // accepted level restarts the stability count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule : key_debounce

`default_nettype wire

// File: rtl/slice_ctrl.sv
// ============================================================================
//  Module      : slice_ctrl
//  Description : Slice job controller. Debounced start/pause keys drive an
//                IDLE/RUN/PAUSE/DONE FSM that hands slices to a processing
//                core and counts their completion acknowledgements.
//
//  Ports       : clk          in  system clock (rising edge)
//                rst_n        in  asynchronous active-low reset
//                key_start_n  in  raw start key, active-low
//                key_pause_n  in  raw pause key, active-low
//                slice_ack_i  in  one-cycle slice-finished pulse from core
//                slice_req_o  out core may process slices while high
//                start_o      out one-cycle pulse on every job (re)start
//                pause_o      out high while paused
//                slice_num_o  out completed-slice count, 0..NUM_SLICES
//                finish_o     out high while job complete
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_ctrl
  import slice_pkg::*;
#(
  parameter int NUM_SLICES = DEFAULT_NUM_SLICES,
  parameter int DB_CYCLES  = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_start_n,
  input  logic               key_pause_n,
  input  logic               slice_ack_i,
  output logic               slice_req_o,
  output logic               start_o,
  output logic               pause_o,
  output logic [SLICE_W-1:0] slice_num_o,
  output logic               finish_o
);

  localparam logic [SLICE_W-1:0] c_NUM = SLICE_W'(NUM_SLICES);

  logic w_start_press;
  logic w_pause_press;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_start_n),
    .o_press (w_start_press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_pause_n),
    .o_press (w_pause_press)
  );

  state_t             r_state;
  logic [SLICE_W-1:0] r_num;
  logic               r_start;
  logic               r_req;
  logic               r_pause;
  logic               r_finish;

  state_t             w_nxt_state;
  logic [SLICE_W-1:0] w_nxt_num;
  logic               w_nxt_start;
  logic [SLICE_W-1:0] w_num_inc;
  logic               w_can_count;
  logic               w_last;

  assign w_num_inc   = r_num + 1'b1;
  // Saturation guard: the count is never allowed past NUM_SLICES.
  assign w_can_count = slice_ack_i && (r_num < c_NUM);
  assign w_last      = (w_num_inc == c_NUM);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_num   = r_num;
    w_nxt_start = 1'b0;

    // A start press overrides everything, including a coincident ack.
    if (w_start_press) begin
      w_nxt_state = RUN;
      w_nxt_num   = '0;
      w_nxt_start = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_can_count) begin
            w_nxt_num = w_num_inc;
          end
          // Completing the last slice wins over a coincident pause press.
          if (w_can_count && w_last) begin
            w_nxt_state = DONE;
          end else if (w_pause_press) begin
            w_nxt_state = PAUSE;
          end
        end
        PAUSE: begin
          // The in-flight slice may still complete while paused.
          if (w_can_count) begin
            w_nxt_num = w_num_inc;
          end
          if (w_can_count && w_last) begin
            w_nxt_state = DONE;
          end else if (w_pause_press) begin
            w_nxt_state = RUN;
          end
        end
        default: begin
          // IDLE and DONE ignore acks and pause presses.
        end
      endcase
    end
  end

  // Outputs are registered alongside the state, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_num    <= '0;
      r_start  <= 1'b0;
      r_req    <= 1'b0;
      r_pause  <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_num    <= w_nxt_num;
      r_start  <= w_nxt_start;
      r_req    <= (w_nxt_state == RUN);
      r_pause  <= (w_nxt_state == PAUSE);
      r_finish <= (w_nxt_state == DONE);
    end
  end

  assign slice_req_o = r_req;
  assign start_o     = r_start;
  assign pause_o     = r_pause;
  assign slice_num_o = r_num;
  assign finish_o    = r_finish;

endmodule : slice_ctrl

`default_nettype wire

// File: tb/tb_slice_ctrl.sv
// ============================================================================
//  Module      : tb_slice_ctrl
//  Description : Directed self-checking bench for slice_ctrl with
//                DB_CYCLES=4 and NUM_SLICES=16. A raw key edge driven just
//                after clock edge N is acted on by the FSM at edge N+7.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slice_ctrl;

  logic       clk;
  logic       rst_n;
  logic       key_start_n;
  logic       key_pause_n;
  logic       slice_ack_i;
  logic       slice_req_o;
  logic       start_o;
  logic       pause_o;
  logic [4:0] slice_num_o;
  logic       finish_o;

  int n_checks = 0;
  int n_fails  = 0;
  int tb_changes;
  logic tb_prev;

  slice_ctrl #(.NUM_SLICES(16), .DB_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_start_n (key_start_n),
    .key_pause_n (key_pause_n),
    .slice_ack_i (slice_ack_i),
    .slice_req_o (slice_req_o),
    .start_o     (start_o),
    .pause_o     (pause_o),
    .slice_num_o (slice_num_o),
    .finish_o    (finish_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_once();
    slice_ack_i = 1'b1;
    tick(1);
    slice_ack_i = 1'b0;
  endtask

  // Full press-and-release of a key without checks; leaves the key settled.
  task automatic press_quiet(input bit is_start);
    if (is_start) key_start_n = 1'b0; else key_pause_n = 1'b0;
    tick(7);
    if (is_start) key_start_n = 1'b1; else key_pause_n = 1'b1;
    tick(8);
  endtask

  // Hold pause key at a level for n cycles, counting pause_o changes.
  task automatic hold_pause(input logic lvl, input int n);
    key_pause_n = lvl;
    repeat (n) begin
      tick(1);
      if (pause_o !== tb_prev) tb_changes++;
      tb_prev = pause_o;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (slice_req_o !== 1'b0) begin n_fails++; $display("FAIL reset_req: got %b want 0", slice_req_o); end
    n_checks++; if (start_o !== 1'b0) begin n_fails++; $display("FAIL reset_start: got %b want 0", start_o); end
    n_checks++; if (pause_o !== 1'b0) begin n_fails++; $display("FAIL reset_pause: got %b want 0", pause_o); end
    n_checks++; if (slice_num_o !== 5'd0) begin n_fails++; $display("FAIL reset_num: got %0d want 0", slice_num_o); end
    n_checks++; if (finish_o !== 1'b0) begin n_fails++; $display("FAIL reset_finish: got %b want 0", finish_o); end
  endtask

  task automatic test_start();
    key_start_n = 1'b0;
    tick(6);
    n_checks++; if (start_o !== 1'b0) begin n_fails++; $display("FAIL start_early: got %b want 0", start_o); end
    tick(1);
    n_checks++; if (start_o !== 1'b1) begin n_fails++; $display("FAIL start_pulse: got %b want 1", start_o); end
    n_checks++; if (slice_req_o !== 1'b1) begin n_fails++; $display("FAIL start_req: got %b want 1", slice_req_o); end
    n_checks++; if (slice_num_o !== 5'd0) begin n_fails++; $display("FAIL start_num: got %0d want 0", slice_num_o); end
    tick(1);
    n_checks++; if (start_o !== 1'b0) begin n_fails++; $display("FAIL start_one_cycle: got %b want 0", start_o); end
    tick(12);
    key_start_n = 1'b1;
    tick(8);
    n_checks++; if (start_o !== 1'b0) begin n_fails++; $display("FAIL start_release: got %b want 0", start_o); end
    n_checks++; if (slice_req_o !== 1'b1) begin n_fails++; $display("FAIL start_still_run: got %b want 1", slice_req_o); end
  endtask

  task automatic test_count();
    for (int i = 1; i <= 16; i++) begin
      ack_once();
      n_checks++; if (slice_num_o !== 5'(i)) begin n_fails++; $display("FAIL count_%0d: got %0d want %0d", i, slice_num_o, i); end
    end
    n_checks++; if (finish_o !== 1'b1) begin n_fails++; $display("FAIL count_finish: got %b want 1", finish_o); end
    n_checks++; if (slice_req_o !== 1'b0) begin n_fails++; $display("FAIL count_req_done: got %b want 0", slice_req_o); end
    ack_once();
    n_checks++; if (slice_num_o !== 5'd16) begin n_fails++; $display("FAIL count_saturate: got %0d want 16", slice_num_o); end
    n_checks++; if (finish_o !== 1'b1) begin n_fails++; $display("FAIL count_finish_hold: got %b want 1", finish_o); end
  endtask

  task automatic test_restart_done();
    key_start_n = 1'b0;
    tick(7);
    n_checks++; if (start_o !== 1'b1) begin n_fails++; $display("FAIL restart_pulse: got %b want 1", start_o); end
    n_checks++; if (slice_num_o !== 5'd0) begin n_fails++; $display("FAIL restart_num: got %0d want 0", slice_num_o); end
    n_checks++; if (finish_o !== 1'b0) begin n_fails++; $display("FAIL restart_finish: got %b want 0", finish_o); end
    n_checks++; if (slice_req_o !== 1'b1) begin n_fails++; $display("FAIL restart_req: got %b want 1", slice_req_o); end
    key_start_n = 1'b1;
    tick(8);
  endtask

  task automatic test_pause();
    repeat (5) ack_once();
    key_pause_n = 1'b0;
    tick(7);
    n_checks++; if (pause_o !== 1'b1) begin n_fails++; $display("FAIL pause_on: got %b want 1", pause_o); end
    n_checks++; if (slice_req_o !== 1'b0) begin n_fails++; $display("FAIL pause_req: got %b want 0", slice_req_o); end
    n_checks++; if (slice_num_o !== 5'd5) begin n_fails++; $display("FAIL pause_num: got %0d want 5", slice_num_o); end
    key_pause_n = 1'b1;
    tick(8);
    ack_once();
    n_checks++; if (slice_num_o !== 5'd6) begin n_fails++; $display("FAIL pause_ack: got %0d want 6", slice_num_o); end
    n_checks++; if (pause_o !== 1'b1) begin n_fails++; $display("FAIL pause_hold: got %b want 1", pause_o); end
    key_pause_n = 1'b0;
    tick(7);
    n_checks++; if (pause_o !== 1'b0) begin n_fails++; $display("FAIL resume_pause: got %b want 0", pause_o); end
    n_checks++; if (slice_req_o !== 1'b1) begin n_fails++; $display("FAIL resume_req: got %b want 1", slice_req_o); end
    key_pause_n = 1'b1;
    tick(8);
  endtask

  task automatic test_bounce();
    // Starts in RUN with pause_o low: one press pulse toggles it exactly once.
    tb_changes = 0;
    tb_prev    = pause_o;
    hold_pause(1'b0, 3);
    hold_pause(1'b1, 3);
    hold_pause(1'b0, 3);
    hold_pause(1'b1, 3);
    hold_pause(1'b0, 20);
    n_checks++; if (tb_changes !== 1) begin n_fails++; $display("FAIL bounce_pulses: got %0d want 1", tb_changes); end
    n_checks++; if (pause_o !== 1'b1) begin n_fails++; $display("FAIL bounce_paused: got %b want 1", pause_o); end
    hold_pause(1'b1, 8);
    press_quiet(1'b0);
    tb_changes = 0;
    tb_prev    = pause_o;
    hold_pause(1'b0, 3);
    hold_pause(1'b1, 15);
    n_checks++; if (tb_changes !== 0) begin n_fails++; $display("FAIL glitch_pulses: got %0d want 0", tb_changes); end
    n_checks++; if (pause_o !== 1'b0) begin n_fails++; $display("FAIL glitch_pause: got %b want 0", pause_o); end
  endtask

  task automatic test_simul();
    press_quiet(1'b1);
    repeat (15) ack_once();
    n_checks++; if (slice_num_o !== 5'd15) begin n_fails++; $display("FAIL simul_pre: got %0d want 15", slice_num_o); end
    key_pause_n = 1'b0;
    tick(6);
    slice_ack_i = 1'b1;
    tick(1);
    slice_ack_i = 1'b0;
    n_checks++; if (slice_num_o !== 5'd16) begin n_fails++; $display("FAIL simul_num: got %0d want 16", slice_num_o); end
    n_checks++; if (finish_o !== 1'b1) begin n_fails++; $display("FAIL simul_finish: got %b want 1", finish_o); end
    n_checks++; if (pause_o !== 1'b0) begin n_fails++; $display("FAIL simul_pause: got %b want 0", pause_o); end
    key_pause_n = 1'b1;
    tick(8);
    key_start_n = 1'b0;
    tick(7);
    n_checks++; if (start_o !== 1'b1) begin n_fails++; $display("FAIL simul_restart: got %b want 1", start_o); end
    n_checks++; if (slice_num_o !== 5'd0) begin n_fails++; $display("FAIL simul_restart_num: got %0d want 0", slice_num_o); end
    n_checks++; if (slice_req_o !== 1'b1) begin n_fails++; $display("FAIL simul_restart_req: got %b want 1", slice_req_o); end
    key_start_n = 1'b1;
    tick(8);
  endtask

  task automatic test_ack_with_start();
    repeat (3) ack_once();
    key_start_n = 1'b0;
    tick(6);
    slice_ack_i = 1'b1;
    tick(1);
    slice_ack_i = 1'b0;
    n_checks++; if (slice_num_o !== 5'd0) begin n_fails++; $display("FAIL ackstart_num: got %0d want 0", slice_num_o); end
    n_checks++; if (start_o !== 1'b1) begin n_fails++; $display("FAIL ackstart_pulse: got %b want 1", start_o); end
    key_start_n = 1'b1;
    tick(8);
  endtask

  task automatic test_reset_mid();
    repeat (9) ack_once();
    press_quiet(1'b0);
    n_checks++; if (pause_o !== 1'b1 || slice_num_o !== 5'd9) begin n_fails++; $display("FAIL rstmid_pre: got pause=%b num=%0d want pause=1 num=9", pause_o, slice_num_o); end
    rst_n = 1'b0;
    #1;
    test_reset();
    tick(2);
    rst_n = 1'b1;
    tick(10);
    n_checks++; if (start_o !== 1'b0 || finish_o !== 1'b0 || slice_req_o !== 1'b0) begin n_fails++; $display("FAIL rstmid_idle: got start=%b finish=%b req=%b want 0 0 0", start_o, finish_o, slice_req_o); end
    press_quiet(1'b0);
    n_checks++; if (pause_o !== 1'b0 || slice_req_o !== 1'b0) begin n_fails++; $display("FAIL idle_pause_ignored: got pause=%b req=%b want 0 0", pause_o, slice_req_o); end
    ack_once();
    n_checks++; if (slice_num_o !== 5'd0) begin n_fails++; $display("FAIL idle_ack_ignored: got %0d want 0", slice_num_o); end
    key_start_n = 1'b0;
    tick(6);
    n_checks++; if (start_o !== 1'b0) begin n_fails++; $display("FAIL post_rst_early: got %b want 0", start_o); end
    tick(1);
    n_checks++; if (start_o !== 1'b1) begin n_fails++; $display("FAIL post_rst_start: got %b want 1", start_o); end
    key_start_n = 1'b1;
    tick(8);
  endtask

  initial begin
    rst_n       = 1'b1;
    key_start_n = 1'b1;
    key_pause_n = 1'b1;
    slice_ack_i = 1'b0;
    #2 rst_n = 1'b0;
    tick(3);
    test_reset();
    rst_n = 1'b1;
    tick(2);
    test_start();
    test_count();
    test_restart_done();
    test_pause();
    test_bounce();
    test_simul();
    test_ack_with_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_slice_ctrl

`default_nettype wire
